// File: rtl/unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unit_pkg : shared type codes, slot state encoding and helpers for squads   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package unit_pkg;

  localparam logic [1:0] TYPE_NONE = 2'd0;
  localparam logic [1:0] TYPE_1    = 2'd1;
  localparam logic [1:0] TYPE_2    = 2'd2;
  localparam logic [1:0] TYPE_3    = 2'd3;

  typedef enum logic [2:0] {
    SLOT_IDLE   = 3'b001,
    SLOT_DEPLOY = 3'b010,
    SLOT_ALIVE  = 3'b100
  } slot_state_e;

  function automatic int unsigned power_of(input logic [1:0] t, input int unsigned p1,
                                           input int unsigned p2, input int unsigned p3);
    case (t)
      TYPE_1:  return p1;
      TYPE_2:  return p2;
      TYPE_3:  return p3;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned spawn_pos(input int unsigned dir, input int unsigned pos_w);
    return (dir == 0) ? ((32'd1 << pos_w) - 32'd1) : 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unit_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unit_slot : one squad slot - lifecycle FSM, health, power, march, attack   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module unit_slot
  import unit_pkg::*;
#(
  parameter int unsigned POS_W  = 9,
  parameter int unsigned HP_W   = 8,
  parameter int unsigned DIR    = 0,
  parameter int unsigned HP_MAX = 255,
  parameter int unsigned POWER1 = 32,
  parameter int unsigned POWER2 = 64,
  parameter int unsigned POWER3 = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              deploy_en,
  input  logic [1:0]        deploy_type,
  input  logic              move_tick,
  input  logic              hit_en,
  input  logic [HP_W-1:0]   damage_in,
  input  logic [POS_W-1:0]  enemy_front,
  output slot_state_e       state,
  output logic [POS_W-1:0]  pos,
  output logic [1:0]        unit_type,
  output logic              attacking,
  output logic [HP_W-1:0]   power
);

  localparam logic [POS_W-1:0] SPAWN = POS_W'(spawn_pos(DIR, POS_W));

  slot_state_e       state_q, state_d;
  logic [1:0]        kind_q, kind_d;
  logic [1:0]        type_q, type_d;
  logic [HP_W-1:0]   health_q, health_d;
  logic [HP_W-1:0]   power_q, power_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              attacking_q, attacking_d;
  logic              reached;
  logic              fatal;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    type_d      = type_q;
    health_d    = health_q;
    power_d     = power_q;
    pos_d       = pos_q;
    attacking_d = attacking_q;
    reached     = (DIR == 0) ? (enemy_front >= pos_q) : (enemy_front <= pos_q);
    fatal       = (damage_in != '0) && (health_q <= damage_in);

    case (state_q)
      SLOT_IDLE: begin
        if (deploy_en) begin
          state_d = SLOT_DEPLOY;
          kind_d  = deploy_type;
        end
      end
      SLOT_DEPLOY: begin
        state_d  = SLOT_ALIVE;
        health_d = HP_W'(HP_MAX);
        power_d  = HP_W'(power_of(kind_q, POWER1, POWER2, POWER3));
        type_d   = kind_q;
      end
      SLOT_ALIVE: begin
        // A killing hit pre-empts any move in the same cycle
        if (hit_en && fatal) begin
          state_d     = SLOT_IDLE;
          type_d      = TYPE_NONE;
          health_d    = '0;
          power_d     = '0;
          pos_d       = SPAWN;
          attacking_d = 1'b0;
        end else begin
          if (hit_en) health_d = health_q - damage_in;
          if (move_tick) begin
            attacking_d = reached;
            if (!reached) begin
              if (DIR == 0) begin
                if (pos_q != '0) pos_d = pos_q - 1'b1;
              end else begin
                if (pos_q != '1) pos_d = pos_q + 1'b1;
              end
            end
          end
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SLOT_IDLE;
      kind_q      <= TYPE_NONE;
      type_q      <= TYPE_NONE;
      health_q    <= '0;
      power_q     <= '0;
      pos_q       <= SPAWN;
      attacking_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      type_q      <= type_d;
      health_q    <= health_d;
      power_q     <= power_d;
      pos_q       <= pos_d;
      attacking_q <= attacking_d;
    end
  end

  assign state     = state_q;
  assign pos       = pos_q;
  assign unit_type = type_q;
  assign attacking = attacking_q;
  assign power     = power_q;

endmodule
`default_nettype wire

// File: rtl/unit_squad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unit_squad : slot bank with allocation, front selection, damage summing    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module unit_squad
  import unit_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned POS_W     = 9,
  parameter int unsigned HP_W      = 8,
  parameter int unsigned DIR       = 0,
  parameter int unsigned HP_MAX    = 255,
  parameter int unsigned POWER1    = 32,
  parameter int unsigned POWER2    = 64,
  parameter int unsigned POWER3    = 128,
  parameter int unsigned SPAWN_GAP = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            purchase,
  input  logic [1:0]                      type_sel,
  input  logic                            move_tick,
  input  logic                            damage_tick,
  input  logic [HP_W-1:0]                 damage_in,
  input  logic [POS_W-1:0]                enemy_front,
  output logic                            purchase_ack,
  output logic                            purchase_reject,
  output logic                            full,
  output logic [$clog2(NUM_UNITS+1)-1:0]  alive_count,
  output logic [POS_W-1:0]                front_pos,
  output logic                            front_valid,
  output logic [HP_W-1:0]                 damage_out,
  output logic [NUM_UNITS*POS_W-1:0]      unit_pos,
  output logic [NUM_UNITS*2-1:0]          unit_type
);

  localparam int unsigned CNT_W = $clog2(NUM_UNITS + 1);
  localparam int unsigned CD_W  = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;
  localparam int unsigned SUM_W = HP_W + CNT_W;
  localparam logic [POS_W-1:0] SPAWN = POS_W'(spawn_pos(DIR, POS_W));

  slot_state_e       slot_state [NUM_UNITS];
  logic [POS_W-1:0]  slot_pos   [NUM_UNITS];
  logic [1:0]        slot_type  [NUM_UNITS];
  logic              slot_att   [NUM_UNITS];
  logic [HP_W-1:0]   slot_pow   [NUM_UNITS];

  logic [NUM_UNITS-1:0] alloc_oh, front_oh, deploy_en, hit_en;
  logic                 any_idle, accept;
  logic [CNT_W-1:0]     alive_w;
  logic [POS_W-1:0]     front_pos_w;
  logic                 front_valid_w;
  logic [SUM_W-1:0]     sum_w;
  logic [HP_W-1:0]      sum_sat;

  logic              ack_q, ack_d;
  logic              reject_q, reject_d;
  logic [CD_W-1:0]   cooldown_q, cooldown_d;
  logic [HP_W-1:0]   damage_q, damage_d;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_slot
    unit_slot #(
      .POS_W (POS_W), .HP_W (HP_W), .DIR (DIR), .HP_MAX (HP_MAX),
      .POWER1 (POWER1), .POWER2 (POWER2), .POWER3 (POWER3)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .deploy_en   (deploy_en[i]),
      .deploy_type (type_sel),
      .move_tick   (move_tick),
      .hit_en      (hit_en[i]),
      .damage_in   (damage_in),
      .enemy_front (enemy_front),
      .state       (slot_state[i]),
      .pos         (slot_pos[i]),
      .unit_type   (slot_type[i]),
      .attacking   (slot_att[i]),
      .power       (slot_pow[i])
    );
    assign unit_pos[i*POS_W +: POS_W] = slot_pos[i];
    assign unit_type[i*2 +: 2]        = slot_type[i];
  end

  // Allocation, occupancy, front selection (lowest index wins ties) and attack sum
  always_comb begin
    any_idle      = 1'b0;
    alloc_oh      = '0;
    alive_w       = '0;
    front_valid_w = 1'b0;
    front_oh      = '0;
    front_pos_w   = SPAWN;
    sum_w         = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (slot_state[i] == SLOT_IDLE) begin
        if (!any_idle) alloc_oh[i] = 1'b1;
        any_idle = 1'b1;
      end else begin
        alive_w = alive_w + 1'b1;
      end
      if (slot_state[i] == SLOT_ALIVE) begin
        if (!front_valid_w ||
            ((DIR == 0) ? (slot_pos[i] < front_pos_w) : (slot_pos[i] > front_pos_w))) begin
          front_valid_w = 1'b1;
          front_oh      = '0;
          front_oh[i]   = 1'b1;
          front_pos_w   = slot_pos[i];
        end
        if (slot_att[i]) sum_w = sum_w + SUM_W'(slot_pow[i]);
      end
    end
    sum_sat = (sum_w > SUM_W'({HP_W{1'b1}})) ? {HP_W{1'b1}} : sum_w[HP_W-1:0];
  end

  always_comb begin
    accept     = purchase && (type_sel != TYPE_NONE) && any_idle && (cooldown_q == '0);
    deploy_en  = accept ? alloc_oh : '0;
    hit_en     = damage_tick ? front_oh : '0;
    ack_d      = accept;
    reject_d   = purchase && !accept;
    cooldown_d = cooldown_q;
    if (accept)                               cooldown_d = CD_W'(SPAWN_GAP);
    else if (move_tick && cooldown_q != '0)   cooldown_d = cooldown_q - 1'b1;
    damage_d   = move_tick ? sum_sat : damage_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q      <= 1'b0;
      reject_q   <= 1'b0;
      cooldown_q <= '0;
      damage_q   <= '0;
    end else begin
      ack_q      <= ack_d;
      reject_q   <= reject_d;
      cooldown_q <= cooldown_d;
      damage_q   <= damage_d;
    end
  end

  assign purchase_ack    = ack_q;
  assign purchase_reject = reject_q;
  assign full            = !any_idle;
  assign alive_count     = alive_w;
  assign front_pos       = front_pos_w;
  assign front_valid     = front_valid_w;
  assign damage_out      = damage_q;

endmodule
`default_nettype wire

// File: tb/tb_unit_squad.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_unit_squad : directed vectors for a DIR=0 and a DIR=1 squad             |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_unit_squad;

  localparam int NU = 4;
  localparam int PW = 9;
  localparam int HW = 8;
  localparam int AW = $clog2(NU + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Player squad (DIR=0)
  logic reset, purchase, move_tick, damage_tick;
  logic [1:0] type_sel;
  logic [HW-1:0] damage_in;
  logic [PW-1:0] enemy_front;
  logic ack, rej, full, fval;
  logic [AW-1:0] alive;
  logic [PW-1:0] fpos;
  logic [HW-1:0] dmg;
  logic [NU*PW-1:0] upos;
  logic [NU*2-1:0] utype;

  // Enemy squad (DIR=1)
  logic reset_b, purchase_b, move_tick_b, damage_tick_b;
  logic [1:0] type_sel_b;
  logic [HW-1:0] damage_in_b;
  logic [PW-1:0] enemy_front_b;
  logic ack_b, rej_b, full_b, fval_b;
  logic [AW-1:0] alive_b;
  logic [PW-1:0] fpos_b;
  logic [HW-1:0] dmg_b;
  logic [NU*PW-1:0] upos_b;
  logic [NU*2-1:0] utype_b;

  unit_squad #(.DIR(0)) dut_a (
    .clk(clk), .reset(reset), .purchase(purchase), .type_sel(type_sel),
    .move_tick(move_tick), .damage_tick(damage_tick), .damage_in(damage_in),
    .enemy_front(enemy_front), .purchase_ack(ack), .purchase_reject(rej),
    .full(full), .alive_count(alive), .front_pos(fpos), .front_valid(fval),
    .damage_out(dmg), .unit_pos(upos), .unit_type(utype)
  );

  unit_squad #(.DIR(1)) dut_b (
    .clk(clk), .reset(reset_b), .purchase(purchase_b), .type_sel(type_sel_b),
    .move_tick(move_tick_b), .damage_tick(damage_tick_b), .damage_in(damage_in_b),
    .enemy_front(enemy_front_b), .purchase_ack(ack_b), .purchase_reject(rej_b),
    .full(full_b), .alive_count(alive_b), .front_pos(fpos_b), .front_valid(fval_b),
    .damage_out(dmg_b), .unit_pos(upos_b), .unit_type(utype_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pos_a(input int i);
    return 32'(upos[i*PW +: PW]);
  endfunction
  function automatic logic [31:0] typ_a(input int i);
    return 32'(utype[i*2 +: 2]);
  endfunction
  function automatic logic [31:0] pos_b(input int i);
    return 32'(upos_b[i*PW +: PW]);
  endfunction
  function automatic logic [31:0] typ_b(input int i);
    return 32'(utype_b[i*2 +: 2]);
  endfunction

  // One clock of stimulus on squad A (sel=0) or B (sel=1); strobes drop afterwards
  task automatic cyc(input bit sel, input bit p, input logic [1:0] ts, input bit mt,
                     input bit dt, input logic [HW-1:0] din);
    if (!sel) begin
      purchase = p; type_sel = ts; move_tick = mt; damage_tick = dt; damage_in = din;
    end else begin
      purchase_b = p; type_sel_b = ts; move_tick_b = mt; damage_tick_b = dt; damage_in_b = din;
    end
    @(posedge clk); #1;
    purchase = 0; type_sel = 0; move_tick = 0; damage_tick = 0; damage_in = 0;
    purchase_b = 0; type_sel_b = 0; move_tick_b = 0; damage_tick_b = 0; damage_in_b = 0;
  endtask

  task automatic ticks(input bit sel, input int n);
    for (int k = 0; k < n; k++) cyc(sel, 0, 2'd0, 1, 0, '0);
  endtask

  typedef struct {
    bit         p;
    logic [1:0] ts;
    bit         mt;
    bit         ack;
    bit         rej;
    int         alive;
    bit         fv;
    int         fp;
    int         dmg;
    int         pos0;
    int         type0;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit vp, logic [1:0] vts, bit vmt, bit vack, bit vrej, int valive,
                              bit vfv, int vfp, int vdmg, int vpos0, int vtype0);
    tbl.push_back('{p:vp, ts:vts, mt:vmt, ack:vack, rej:vrej, alive:valive, fv:vfv,
                    fp:vfp, dmg:vdmg, pos0:vpos0, type0:vtype0});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1; reset_b = 1;
    purchase = 0; type_sel = 0; move_tick = 0; damage_tick = 0; damage_in = 0; enemy_front = 9'd505;
    purchase_b = 0; type_sel_b = 0; move_tick_b = 0; damage_tick_b = 0; damage_in_b = 0;
    enemy_front_b = 9'd3;

    //  p  ts  mt  ack rej alive fv  fp   dmg pos0 type0
    add(0, 0, 0,  0, 0,  0,  0, 511,  0, 511, 0);
    add(1, 2, 0,  1, 0,  1,  0, 511,  0, 511, 0);
    add(0, 0, 0,  0, 0,  1,  1, 511,  0, 511, 2);
    add(1, 2, 0,  0, 1,  1,  1, 511,  0, 511, 2);
    add(1, 0, 0,  0, 1,  1,  1, 511,  0, 511, 2);
    for (int q = 510; q >= 505; q--) add(0, 0, 1, 0, 0, 1, 1, q, 0, q, 2);
    add(0, 0, 1,  0, 0,  1,  1, 505,  0, 505, 2);
    add(1, 1, 1,  0, 1,  1,  1, 505, 64, 505, 2);
    add(1, 0, 1,  0, 1,  1,  1, 505, 64, 505, 2);
    add(0, 0, 1,  0, 0,  1,  1, 505, 64, 505, 2);
    add(1, 3, 0,  1, 0,  2,  1, 505, 64, 505, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("rst alive", 32'(alive), 0);
    chk("rst pos3", pos_a(3), 511);
    chk("rst dmg", 32'(dmg), 0);
    chk("rst_b pos0", pos_b(0), 0);
    chk("rst_b fpos", 32'(fpos_b), 0);
    reset = 0; reset_b = 0;

    for (int k = 0; k < tbl.size(); k++) begin
      cyc(0, tbl[k].p, tbl[k].ts, tbl[k].mt, 0, '0);
      chk($sformatf("v%0d ack", k),   32'(ack),   32'(tbl[k].ack));
      chk($sformatf("v%0d rej", k),   32'(rej),   32'(tbl[k].rej));
      chk($sformatf("v%0d full", k),  32'(full),  0);
      chk($sformatf("v%0d alive", k), 32'(alive), tbl[k].alive);
      chk($sformatf("v%0d fval", k),  32'(fval),  32'(tbl[k].fv));
      chk($sformatf("v%0d fpos", k),  32'(fpos),  tbl[k].fp);
      chk($sformatf("v%0d dmg", k),   32'(dmg),   tbl[k].dmg);
      chk($sformatf("v%0d pos0", k),  pos_a(0),   tbl[k].pos0);
      chk($sformatf("v%0d type0", k), typ_a(0),   tbl[k].type0);
    end

    // Fill the remaining slots, one SPAWN_GAP apart
    ticks(0, 9);
    chk("fill dmg 64+128", 32'(dmg), 192);
    chk("fill pos1", pos_a(1), 505);
    chk("fill type1", typ_a(1), 3);
    cyc(0, 1, 2'd3, 0, 0, '0);
    chk("fill ack2", 32'(ack), 1);
    ticks(0, 9);
    chk("sat dmg", 32'(dmg), 255);
    chk("fill pos2", pos_a(2), 505);
    cyc(0, 1, 2'd1, 0, 0, '0);
    chk("fill ack3", 32'(ack), 1);
    chk("full set", 32'(full), 1);
    chk("alive 4", 32'(alive), 4);
    cyc(0, 1, 2'd1, 0, 0, '0);
    chk("cooldown rej", 32'(rej), 1);
    ticks(0, 9);
    cyc(0, 1, 2'd1, 0, 0, '0);
    chk("full rej", 32'(rej), 1);
    chk("full ack", 32'(ack), 0);
    chk("full fpos", 32'(fpos), 505);

    // Damage the front (slot 0 by tie-break), exact-equal damage kills
    cyc(0, 0, 2'd0, 0, 1, 8'd100);
    cyc(0, 0, 2'd0, 0, 1, 8'd100);
    cyc(0, 0, 2'd0, 0, 1, 8'd54);
    chk("hp1 type0", typ_a(0), 2);
    cyc(0, 0, 2'd0, 0, 1, 8'd0);
    chk("zero dmg type0", typ_a(0), 2);
    chk("zero dmg alive", 32'(alive), 4);
    cyc(0, 0, 2'd0, 0, 1, 8'd1);
    chk("kill type0", typ_a(0), 0);
    chk("kill pos0", pos_a(0), 511);
    chk("kill alive", 32'(alive), 3);
    chk("kill full", 32'(full), 0);

    // Fatal hit with a move: dead slot does not move, survivors do
    enemy_front = 9'd0;
    cyc(0, 0, 2'd0, 1, 1, 8'd255);
    chk("fatal+move type1", typ_a(1), 0);
    chk("fatal+move pos1", pos_a(1), 511);
    chk("fatal+move pos2", pos_a(2), 504);
    chk("fatal+move fpos", 32'(fpos), 504);
    chk("fatal+move alive", 32'(alive), 2);
    cyc(0, 0, 2'd0, 1, 1, 8'd10);
    chk("hit+move pos2", pos_a(2), 503);
    chk("hit+move type2", typ_a(2), 3);
    chk("hit+move dmg", 32'(dmg), 0);
    cyc(0, 1, 2'd2, 0, 0, '0);
    chk("realloc ack", 32'(ack), 1);
    cyc(0, 0, 2'd0, 0, 0, '0);
    chk("realloc type0", typ_a(0), 2);

    // Enemy squad: spawn at 0 and march upward
    cyc(1, 1, 2'd1, 0, 0, '0);
    chk("b ack", 32'(ack_b), 1);
    cyc(1, 0, 2'd0, 0, 0, '0);
    chk("b type0", typ_b(0), 1);
    chk("b fval", 32'(fval_b), 1);
    chk("b fpos spawn", 32'(fpos_b), 0);
    for (int q = 1; q <= 3; q++) begin
      ticks(1, 1);
      chk($sformatf("b march %0d", q), pos_b(0), q);
    end
    ticks(1, 1);
    chk("b hold", pos_b(0), 3);
    chk("b dmg pre", 32'(dmg_b), 0);
    ticks(1, 1);
    chk("b dmg", 32'(dmg_b), 32);
    ticks(1, 3);
    cyc(1, 1, 2'd2, 0, 0, '0);
    chk("b ack2", 32'(ack_b), 1);
    ticks(1, 1);
    chk("b fpos max", 32'(fpos_b), 3);
    ticks(1, 1);
    chk("b pos1 march", pos_b(1), 1);

    // Asynchronous reset between clock edges
    #2 reset_b = 1;
    #1;
    chk("b arst pos0", pos_b(0), 0);
    chk("b arst pos1", pos_b(1), 0);
    chk("b arst type0", typ_b(0), 0);
    chk("b arst alive", 32'(alive_b), 0);
    chk("b arst dmg", 32'(dmg_b), 0);
    chk("b arst fval", 32'(fval_b), 0);
    chk("b arst ack", 32'(ack_b), 0);
    chk("b arst full", 32'(full_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
